conv_layer_sequencer: RTL

Controller that sequences one pass of the single-layer convolution engine. It fetches image and filter samples from two synchronous-read buffers and streams them into the engine under Start. It then issues the ReadEn burst and returns each window result tagged with its window index. A host requests a pass with a start/busy/done handshake.

---
 rtl/conv_layer_sequencer_if.sv | 38 +++
 rtl/conv_layer_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer_if.sv
// Host, buffer and engine signals of the convolution layer sequencer.
// The slave modport is the sequencer side; master is the environment side.
interface conv_layer_sequencer_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned RES_W  = 10,
    parameter int unsigned IMG_AW = 4,
    parameter int unsigned FLT_AW = 2,
    parameter int unsigned IDX_W  = 3
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [IMG_AW-1:0] img_addr;
    logic [DATA_W-1:0] img_rdata;
    logic [FLT_AW-1:0] flt_addr;
    logic [DATA_W-1:0] flt_rdata;
    logic              conv_start;
    logic [DATA_W-1:0] conv_image;
    logic [DATA_W-1:0] conv_filter;
    logic              conv_read_en;
    logic [RES_W-1:0]  conv_result;
    logic              res_valid;
    logic [RES_W-1:0]  res_data;
    logic [IDX_W-1:0]  res_idx;

    modport slave (
        input  start, abort, img_rdata, flt_rdata, conv_result,
        output busy, done, img_addr, flt_addr, conv_start, conv_image, conv_filter,
               conv_read_en, res_valid, res_data, res_idx
    );

    modport master (
        output start, abort, img_rdata, flt_rdata, conv_result,
        input  busy, done, img_addr, flt_addr, conv_start, conv_image, conv_filter,
               conv_read_en, res_valid, res_data, res_idx
    );
endinterface

// File: rtl/conv_layer_sequencer.sv
// Sequences one pass of the convolution engine: fetch image/filter samples,
// stream them under conv_start, burst-read the window results and return
// each one tagged with its window index.
module conv_layer_sequencer #(
    parameter int unsigned TAPS     = 3,
    parameter int unsigned NUM_WIN  = 5,
    parameter int unsigned STRIDE   = 1,
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned RES_W    = 10,
    parameter int unsigned IMG_AW   = 4,
    parameter int unsigned FLT_AW   = 2,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    conv_layer_sequencer_if.slave bus_io
);

    localparam int unsigned TW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned WW = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
    localparam int unsigned LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    localparam logic [TW-1:0] TLast = TW'(TAPS - 1);
    localparam logic [WW-1:0] WLast = WW'(NUM_WIN - 1);
    localparam logic [LW-1:0] LLast = LW'(READ_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StStream,
        StGap,
        StRead,
        StDrain,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [TW-1:0]       t_q, t_d;
    logic [WW-1:0]       w_q, w_d;
    logic [WW-1:0]       rd_q, rd_d;
    logic [LW-1:0]       lat_q, lat_d;
    logic [WW-1:0]       idx_q, idx_d;
    logic [READ_LAT-1:0] vld_q, vld_d;

    logic              kill;
    logic              read_en;
    logic              res_valid;
    logic [WW-1:0]     aw;
    logic [TW-1:0]     at;
    logic [IMG_AW-1:0] img_addr_c;
    logic [FLT_AW-1:0] flt_addr_c;

    // Abort only acts once a pass is under way; in idle a start always wins.
    assign kill      = bus_io.abort && (state_q != StIdle);
    assign read_en   = (state_q == StRead);
    assign res_valid = vld_q[READ_LAT-1];

    // State, counters and result delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            t_q     <= '0;
            w_q     <= '0;
            rd_q    <= '0;
            lat_q   <= '0;
            idx_q   <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            w_q     <= w_d;
            rd_q    <= rd_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

    // Next-state and phase counters; t is the fast index inside a window.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        w_d     = w_q;
        rd_d    = rd_q;
        lat_d   = lat_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    state_d = StFetch;
                    t_d     = '0;
                    w_d     = '0;
                    rd_d    = '0;
                    lat_d   = '0;
                end
            end
            StFetch: state_d = StStream;
            StStream: begin
                if (t_q == TLast) begin
                    t_d = '0;
                    if (w_q == WLast) begin
                        w_d     = '0;
                        state_d = StGap;
                    end else begin
                        w_d = w_q + WW'(1);
                    end
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            StGap: state_d = StRead;
            StRead: begin
                if (rd_q == WLast) begin
                    rd_d    = '0;
                    state_d = StDrain;
                end else begin
                    rd_d = rd_q + WW'(1);
                end
            end
            StDrain: begin
                if (lat_q == LLast) begin
                    lat_d   = '0;
                    state_d = StDone;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (kill) begin
            state_d = StIdle;
            t_d     = '0;
            w_d     = '0;
            rd_d    = '0;
            lat_d   = '0;
        end
    end

    // Result strobe trails conv_read_en by READ_LAT cycles; index advances per result.
    always_comb begin
        vld_d = READ_LAT'({vld_q, read_en});
        idx_d = idx_q;
        if (res_valid) begin
            idx_d = (idx_q == WLast) ? '0 : idx_q + WW'(1);
        end
        if (kill) begin
            vld_d = '0;
            idx_d = '0;
        end
    end

    // Buffer addresses lead the streamed sample by one cycle (synchronous-read buffers).
    always_comb begin
        aw         = '0;
        at         = '0;
        img_addr_c = '0;
        flt_addr_c = '0;
        if (state_q == StStream) begin
            aw = w_q;
            at = t_q;
            // The final stream cycle has nothing left to fetch, so it holds.
            if (!((w_q == WLast) && (t_q == TLast))) begin
                if (t_q == TLast) begin
                    aw = w_q + WW'(1);
                    at = '0;
                end else begin
                    at = t_q + TW'(1);
                end
            end
        end
        if ((state_q == StFetch) || (state_q == StStream)) begin
            img_addr_c = IMG_AW'(32'(aw) * STRIDE + 32'(at));
            flt_addr_c = FLT_AW'(at);
        end
    end

    assign bus_io.busy         = (state_q != StIdle);
    assign bus_io.done         = (state_q == StDone);
    assign bus_io.img_addr     = img_addr_c;
    assign bus_io.flt_addr     = flt_addr_c;
    assign bus_io.conv_start   = (state_q == StStream);
    assign bus_io.conv_image   = (state_q == StStream) ? bus_io.img_rdata : '0;
    assign bus_io.conv_filter  = (state_q == StStream) ? bus_io.flt_rdata : '0;
    assign bus_io.conv_read_en = read_en;
    assign bus_io.res_valid    = res_valid;
    assign bus_io.res_data     = res_valid ? bus_io.conv_result : '0;
    assign bus_io.res_idx      = idx_q;

endmodule
